id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Parametrised ID/EX pipeline register for the 5-stage MIPS32 core. It sits between the decode stage (id) and the execute stage (ex).
- Beyond plain per-cycle forwarding it adds:
  - pipeline stall control (hold or bubble insertion);
  - flush on exception;
  - delay-slot tracking and link-address/instruction carry-through;
  - a per-slot valid bit and a saturating bubble counter for performance debug.

Parameters:
- REG_W, 32, data/register width.
- ALUOP_W, 8, ALU op code width.
- ALUSEL_W, 3, ALU result-select width.
- REGADDR_W, 5, register address width.
- STALL_W, 6, width of the stall vector from ctrl.
- ID_STALL_IDX, 2, stall bit index for the decode stage.
- EX_STALL_IDX, 3, stall bit index for the execute stage.
- CNT_W, 16, bubble counter width.
- NOP_ALUOP, 0, aluop value loaded for a bubble.
- NOP_ALUSEL, 0, alusel value loaded for a bubble.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  exception flush, clears the slot.
- stall  in  STALL_W  stall vector from ctrl.
- id_valid  in  1  decode output holds a real instruction.
- id_aluop  in  ALUOP_W  op code.
- id_alusel  in  ALUSEL_W  result select.
- id_reg1  in  REG_W  source operand 1.
- id_reg2  in  REG_W  source operand 2.
- id_wd  in  REGADDR_W  destination register address.
- id_wreg  in  1  write enable.
- id_link_addr  in  REG_W  return address for jal/bal-type instructions.
- id_is_in_delayslot  in  1  the current id instruction is in a delay slot.
- id_next_in_delayslot  in  1  the next instruction will be in a delay slot.
- id_inst  in  REG_W  raw instruction word.
- ex_valid  out  1  ex slot holds a real instruction.
- ex_aluop  out  ALUOP_W.
- ex_alusel  out  ALUSEL_W.
- ex_reg1  out  REG_W.
- ex_reg2  out  REG_W.
- ex_wd  out  REGADDR_W.
- ex_wreg  out  1.
- ex_link_addr  out  REG_W.
- ex_is_in_delayslot  out  1.
- ex_inst  out  REG_W.
- is_in_delayslot_o  out  1  fed back to id: the instruction now in decode is a delay slot.
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted.

Behaviour:
- All state updates on the rising edge of clk; no combinational input-to-output paths. Latency is 1 cycle.
- Priority per edge: rst > flush > bubble > hold > pass.
- rst=1:
  - all outputs 0;
  - ex_aluop=NOP_ALUOP, ex_alusel=NOP_ALUSEL;
  - ex_wreg=0, ex_valid=0, is_in_delayslot_o=0, bubble_cnt=0.
- flush=1 (rst=0):
  - same slot values as reset, including is_in_delayslot_o=0;
  - bubble_cnt is unchanged;
  - flush overrides any stall pattern.
- Bubble: stall[ID_STALL_IDX]=1 and stall[EX_STALL_IDX]=0.
  - ex_* slot loads the NOP values, with ex_valid=0 and ex_wreg=0.
  - is_in_delayslot_o holds its value.
  - bubble_cnt increments, saturating at all-ones.
- Hold: stall[ID_STALL_IDX]=1 and stall[EX_STALL_IDX]=1. All outputs hold.
- Pass: stall[ID_STALL_IDX]=0.
  - Every ex_* output loads the matching id_* input; ex_valid<=id_valid.
  - is_in_delayslot_o<=id_next_in_delayslot.
  - This applies whatever stall[EX_STALL_IDX] is. ctrl guarantees stall is monotonic (a set bit implies all lower bits set), so this combination does not occur legally; the pass behaviour is defined anyway for robustness.
- Invalid input: id_valid=0 in pass passes the fields through unchanged, but ex_wreg is forced to 0.
- Counter: only bubbles count, never holds or flushes. It does not wrap: at 2^CNT_W-1 it stays there.
- Stall bits other than ID_STALL_IDX and EX_STALL_IDX are ignored.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with id_aluop=8'h21, id_wreg=1.
  - Required: ex_aluop=0, ex_wreg=0, ex_valid=0 and bubble_cnt=0 after each edge.
- Pass:
  - Stimulus: stall=0; id_reg1=32'h1234_5678, id_wd=5'd3, id_wreg=1, id_valid=1.
  - Required: the ex_* outputs show exactly those values one edge later.
- Hold then bubble:
  - Stimulus: stall=6'b001111 for 2 cycles, then stall=6'b000111 for 1 cycle.
  - Required: outputs are frozen for 2 edges; then ex_aluop=0, ex_wreg=0, ex_valid=0 and bubble_cnt=1.
- Flush beats stall:
  - Stimulus: stall=6'b000111 and flush=1 together.
  - Required: slot cleared, bubble_cnt unchanged, is_in_delayslot_o=0.
- Delay slot:
  - Stimulus: id_next_in_delayslot=1 with stall=0 for 1 cycle.
  - Required: is_in_delayslot_o=1 next edge.
  - Stimulus: the next cycle has id_is_in_delayslot=1 and id_link_addr=32'hbfc0_0010.
  - Required: ex_is_in_delayslot=1 and ex_link_addr=32'hbfc0_0010 one edge later.
- Saturation:
  - Stimulus: CNT_W=2; 5 consecutive bubbles.
  - Required: bubble_cnt goes 1, 2, 3, 3, 3.
  - Stimulus: id_valid=0 with id_wreg=1 in pass.
  - Required: ex_wreg=0.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register for the 5-stage MIPS32 core: stall hold/bubble, exception flush,
// delay-slot feedback to decode, and a saturating bubble counter for performance debug.
module id_ex_pipe #(
  parameter int unsigned           REG_W        = 32,
  parameter int unsigned           ALUOP_W      = 8,
  parameter int unsigned           ALUSEL_W     = 3,
  parameter int unsigned           REGADDR_W    = 5,
  parameter int unsigned           STALL_W      = 6,
  parameter int unsigned           ID_STALL_IDX = 2,
  parameter int unsigned           EX_STALL_IDX = 3,
  parameter int unsigned           CNT_W        = 16,
  parameter logic [ALUOP_W-1:0]    NOP_ALUOP    = '0,
  parameter logic [ALUSEL_W-1:0]   NOP_ALUSEL   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 id_valid,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [REG_W-1:0]     id_reg1,
  input  logic [REG_W-1:0]     id_reg2,
  input  logic [REGADDR_W-1:0] id_wd,
  input  logic                 id_wreg,
  input  logic [REG_W-1:0]     id_link_addr,
  input  logic                 id_is_in_delayslot,
  input  logic                 id_next_in_delayslot,
  input  logic [REG_W-1:0]     id_inst,
  output logic                 ex_valid,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [REG_W-1:0]     ex_reg1,
  output logic [REG_W-1:0]     ex_reg2,
  output logic [REGADDR_W-1:0] ex_wd,
  output logic                 ex_wreg,
  output logic [REG_W-1:0]     ex_link_addr,
  output logic                 ex_is_in_delayslot,
  output logic [REG_W-1:0]     ex_inst,
  output logic                 is_in_delayslot_o,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef struct packed {
    logic                 valid;
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUSEL_W-1:0]  alusel;
    logic [REG_W-1:0]     reg1;
    logic [REG_W-1:0]     reg2;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [REG_W-1:0]     link_addr;
    logic                 is_ds;
    logic [REG_W-1:0]     inst;
  } slot_t;

  slot_t            slot_d, slot_q;
  slot_t            nop_slot, id_slot;
  logic             ds_d, ds_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             id_stall, ex_stall, do_bubble, do_hold;

  assign id_stall  = stall[ID_STALL_IDX];
  assign ex_stall  = stall[EX_STALL_IDX];
  assign do_bubble = id_stall & ~ex_stall;
  assign do_hold   = id_stall & ex_stall;

  always_comb begin
    nop_slot        = '0;
    nop_slot.aluop  = NOP_ALUOP;
    nop_slot.alusel = NOP_ALUSEL;
  end

  // An invalid decode slot still carries its fields but must never write the register file.
  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.aluop     = id_aluop;
    id_slot.alusel    = id_alusel;
    id_slot.reg1      = id_reg1;
    id_slot.reg2      = id_reg2;
    id_slot.wd        = id_wd;
    id_slot.wreg      = id_wreg & id_valid;
    id_slot.link_addr = id_link_addr;
    id_slot.is_ds     = id_is_in_delayslot;
    id_slot.inst      = id_inst;
  end

  always_comb begin
    slot_d = slot_q;
    ds_d   = ds_q;
    cnt_d  = cnt_q;
    if (rst) begin
      slot_d = nop_slot;
      ds_d   = 1'b0;
      cnt_d  = '0;
    end else if (flush) begin
      slot_d = nop_slot;
      ds_d   = 1'b0;
    end else if (do_bubble) begin
      slot_d = nop_slot;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (do_hold) begin
      slot_d = slot_q;
    end else begin
      // Pass also covers the non-monotonic id=0/ex=1 stall pattern.
      slot_d = id_slot;
      ds_d   = id_next_in_delayslot;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
    ds_q   <= ds_d;
    cnt_q  <= cnt_d;
  end

  assign ex_valid           = slot_q.valid;
  assign ex_aluop           = slot_q.aluop;
  assign ex_alusel          = slot_q.alusel;
  assign ex_reg1            = slot_q.reg1;
  assign ex_reg2            = slot_q.reg2;
  assign ex_wd              = slot_q.wd;
  assign ex_wreg            = slot_q.wreg;
  assign ex_link_addr       = slot_q.link_addr;
  assign ex_is_in_delayslot = slot_q.is_ds;
  assign ex_inst            = slot_q.inst;
  assign is_in_delayslot_o  = ds_q;
  assign bubble_cnt         = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus a randomized run, all checked
// against a behavioural model; a second instance with a 2-bit counter covers saturation.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic        id_valid, id_wreg, id_is_in_delayslot, id_next_in_delayslot;
  logic [7:0]  id_aluop;
  logic [2:0]  id_alusel;
  logic [31:0] id_reg1, id_reg2, id_link_addr, id_inst;
  logic [4:0]  id_wd;

  logic        ex_valid, ex_wreg, ex_is_in_delayslot, is_in_delayslot_o;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2, ex_link_addr, ex_inst;
  logic [4:0]  ex_wd;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_wreg, s_isds, s_dso;
  logic [7:0]  s_aluop;
  logic [2:0]  s_alusel;
  logic [31:0] s_reg1, s_reg2, s_link, s_inst;
  logic [4:0]  s_wd;
  logic [1:0]  s_cnt;

  typedef struct packed {
    logic        valid;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] link;
    logic        isds;
    logic [31:0] inst;
    logic        dso;
    logic [15:0] cnt;
  } view_t;

  view_t      obs, mdl;
  logic [1:0] mdl_cnt2;
  int         checks = 0;
  int         errors = 0;

  assign obs = '{valid: ex_valid, aluop: ex_aluop, alusel: ex_alusel, reg1: ex_reg1,
                 reg2: ex_reg2, wd: ex_wd, wreg: ex_wreg, link: ex_link_addr,
                 isds: ex_is_in_delayslot, inst: ex_inst, dso: is_in_delayslot_o,
                 cnt: bubble_cnt};

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .id_valid(id_valid),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_link_addr(id_link_addr),
    .id_is_in_delayslot(id_is_in_delayslot), .id_next_in_delayslot(id_next_in_delayslot),
    .id_inst(id_inst), .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
    .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_link_addr(ex_link_addr), .ex_is_in_delayslot(ex_is_in_delayslot),
    .ex_inst(ex_inst), .is_in_delayslot_o(is_in_delayslot_o), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall), .id_valid(id_valid),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg), .id_link_addr(id_link_addr),
    .id_is_in_delayslot(id_is_in_delayslot), .id_next_in_delayslot(id_next_in_delayslot),
    .id_inst(id_inst), .ex_valid(s_valid), .ex_aluop(s_aluop), .ex_alusel(s_alusel),
    .ex_reg1(s_reg1), .ex_reg2(s_reg2), .ex_wd(s_wd), .ex_wreg(s_wreg),
    .ex_link_addr(s_link), .ex_is_in_delayslot(s_isds),
    .ex_inst(s_inst), .is_in_delayslot_o(s_dso), .bubble_cnt(s_cnt)
  );

  task automatic rand_id();
    id_valid             = 1'($urandom);
    id_aluop             = 8'($urandom);
    id_alusel            = 3'($urandom);
    id_reg1              = $urandom;
    id_reg2              = $urandom;
    id_wd                = 5'($urandom);
    id_wreg              = 1'($urandom);
    id_link_addr         = $urandom;
    id_is_in_delayslot   = 1'($urandom);
    id_next_in_delayslot = 1'($urandom);
    id_inst              = $urandom;
  endtask

  // Reference: decide the action from the rules, then apply it to the expected view.
  task automatic step();
    view_t nxt;
    nxt = mdl;
    if (rst) begin
      nxt      = '0;
      mdl_cnt2 = 2'd0;
    end else if (flush) begin
      nxt     = '0;
      nxt.cnt = mdl.cnt;
    end else if (stall[2] && !stall[3]) begin
      nxt     = '0;
      nxt.dso = mdl.dso;
      nxt.cnt = (mdl.cnt == 16'hffff) ? mdl.cnt : mdl.cnt + 16'd1;
      if (mdl_cnt2 < 2'd3) mdl_cnt2 = mdl_cnt2 + 2'd1;
    end else if (!stall[2]) begin
      nxt = '{valid: id_valid, aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
              reg2: id_reg2, wd: id_wd, wreg: id_wreg && id_valid, link: id_link_addr,
              isds: id_is_in_delayslot, inst: id_inst, dso: id_next_in_delayslot,
              cnt: mdl.cnt};
    end
    mdl = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rand_id();
    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    id_aluop = 8'h21; id_wreg = 1'b1; id_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (ex_aluop !== 8'h00 || ex_wreg !== 1'b0 || ex_valid !== 1'b0 || bubble_cnt !== 16'd0) begin
        errors++;
        $display("FAIL reset[%0d]: aluop=%h wreg=%b valid=%b cnt=%0d required 0/0/0/0",
                 i, ex_aluop, ex_wreg, ex_valid, bubble_cnt);
      end
      checks++;
      if (obs !== mdl || s_cnt !== 2'd0) begin
        errors++;
        $display("FAIL reset_full[%0d]: got %h/%0d required %h/0", i, obs, s_cnt, mdl);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    rand_id();
    stall = 6'b0;
    id_reg1 = 32'h1234_5678; id_wd = 5'd3; id_wreg = 1'b1; id_valid = 1'b1;
    step();
    checks++;
    if (ex_reg1 !== 32'h1234_5678 || ex_wd !== 5'd3 || ex_wreg !== 1'b1 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL pass: reg1=%h wd=%0d wreg=%b valid=%b required 12345678/3/1/1",
               ex_reg1, ex_wd, ex_wreg, ex_valid);
    end
    checks++;
    if (obs !== mdl) begin
      errors++;
      $display("FAIL pass_full: got %h required %h", obs, mdl);
    end
  endtask

  task automatic test_hold_bubble();
    for (int i = 0; i < 2; i++) begin
      rand_id();
      stall = 6'b001111;
      step();
      checks++;
      if (obs !== mdl || ex_reg1 !== 32'h1234_5678 || ex_wd !== 5'd3) begin
        errors++;
        $display("FAIL hold[%0d]: got %h required %h", i, obs, mdl);
      end
    end
    rand_id();
    stall = 6'b000111;
    step();
    checks++;
    if (ex_aluop !== 8'h00 || ex_wreg !== 1'b0 || ex_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
      errors++;
      $display("FAIL bubble: aluop=%h wreg=%b valid=%b cnt=%0d required 0/0/0/1",
               ex_aluop, ex_wreg, ex_valid, bubble_cnt);
    end
    checks++;
    if (obs !== mdl) begin
      errors++;
      $display("FAIL bubble_full: got %h required %h", obs, mdl);
    end
  endtask

  task automatic test_flush();
    logic [15:0] cnt_before;
    rand_id();
    stall = 6'b0; id_valid = 1'b1; id_next_in_delayslot = 1'b1;
    step();
    cnt_before = mdl.cnt;
    rand_id();
    stall = 6'b000111; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_wreg !== 1'b0 || ex_aluop !== 8'h00 || ex_reg1 !== 32'h0 ||
        is_in_delayslot_o !== 1'b0 || bubble_cnt !== cnt_before) begin
      errors++;
      $display("FAIL flush: got %h required cleared slot, dso=0, cnt=%0d", obs, cnt_before);
    end
    checks++;
    if (obs !== mdl) begin
      errors++;
      $display("FAIL flush_full: got %h required %h", obs, mdl);
    end
  endtask

  task automatic test_delay_slot();
    rand_id();
    stall = 6'b0; id_next_in_delayslot = 1'b1;
    step();
    checks++;
    if (is_in_delayslot_o !== 1'b1) begin
      errors++;
      $display("FAIL ds_feedback: got %b required 1", is_in_delayslot_o);
    end
    rand_id();
    id_is_in_delayslot = 1'b1; id_link_addr = 32'hbfc0_0010; id_next_in_delayslot = 1'b0;
    step();
    checks++;
    if (ex_is_in_delayslot !== 1'b1 || ex_link_addr !== 32'hbfc0_0010 || is_in_delayslot_o !== 1'b0) begin
      errors++;
      $display("FAIL ds_carry: isds=%b link=%h dso=%b required 1/bfc00010/0",
               ex_is_in_delayslot, ex_link_addr, is_in_delayslot_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; stall = 6'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_id();
      stall = 6'b000111;
      step();
      checks++;
      if (s_cnt !== exp_seq[i] || s_cnt !== mdl_cnt2 || bubble_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL saturation[%0d]: small=%0d big=%0d required %0d/%0d",
                 i, s_cnt, bubble_cnt, exp_seq[i], i + 1);
      end
    end
  endtask

  task automatic test_invalid();
    rand_id();
    stall = 6'b0; id_valid = 1'b0; id_wreg = 1'b1;
    step();
    checks++;
    if (ex_wreg !== 1'b0 || ex_valid !== 1'b0 || ex_reg2 !== id_reg2 || ex_inst !== id_inst) begin
      errors++;
      $display("FAIL invalid: wreg=%b valid=%b reg2=%h inst=%h required 0/0/%h/%h",
               ex_wreg, ex_valid, ex_reg2, ex_inst, id_reg2, id_inst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_id();
      rst   = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 14) == 0);
      stall = 6'($urandom);
      step();
      checks++;
      if (obs !== mdl || s_cnt !== mdl_cnt2) begin
        errors++;
        $display("FAIL random[%0d]: got %h/%0d required %h/%0d", i, obs, s_cnt, mdl, mdl_cnt2);
      end
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    mdl = '0;
    mdl_cnt2 = 2'd0;
    rst = 1'b1; flush = 1'b0; stall = 6'b0;
    rand_id();
    @(negedge clk);
    test_reset();
    test_pass();
    test_hold_bubble();
    test_flush();
    test_delay_slot();
    test_invalid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
